// File: rtl/bnine_ifq_pkg.sv
// bnine_ifq_pkg
// Shared definitions for the Bnine instruction fetch queue:
//   - FSM state encoding of the fetch controller
//   - layout of one queue entry {pID, address, instruction}
//   - default reset PC and PC increment
package bnine_ifq_pkg;

  // IDLE: nothing outstanding; WAIT: one request outstanding;
  // DROP: one request outstanding whose response must be thrown away.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } ifq_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          PC_STEP          = 4;

  // Entry layout, LSB first: instruction, then address, then pipeline ID.
  localparam int ENTRY_INST_LSB = 0;

  function automatic int entry_addr_lsb(input int inst_w);
    return inst_w;
  endfunction

  function automatic int entry_pid_lsb(input int inst_w, input int addr_w);
    return inst_w + addr_w;
  endfunction

  function automatic int entry_width(input int inst_w, input int addr_w, input int pid_w);
    return inst_w + addr_w + pid_w;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if
// Bundles the fetch-stage signals: redirect (jumpFlag_i/jumpAddr_i), the
// instruction-memory request/response pair and the decoder-side head port.
// Suffixes are from the fetch queue's point of view.
//   master : used by inst_fetch_queue
//   slave  : used by the environment (memory + decoder + redirect source)
// state_dbg exposes the fetch FSM state for observation.
//
// Handshakes:
//   - request_o is a one-cycle pulse; instAddr_fetch_o is meaningful only
//     while it is high. Memory answers each accepted request with exactly one
//     dataOk_i pulse carrying inst_fetch_i, in the same or any later cycle.
//   - The head entry transfers to the decoder in every cycle where
//     valid_o && ready_i; valid_o never depends on ready_i except through the
//     optional bypass path.
interface inst_fetch_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PID_WIDTH  = 2
);
  import bnine_ifq_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  jumpFlag_i;
  logic [ADDR_WIDTH-1:0] jumpAddr_i;
  logic                  request_o;
  logic [ADDR_WIDTH-1:0] instAddr_fetch_o;
  logic                  dataOk_i;
  logic [INST_WIDTH-1:0] inst_fetch_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [INST_WIDTH-1:0] inst_o;
  logic [ADDR_WIDTH-1:0] instAddr_o;
  logic [PID_WIDTH-1:0]  pID_o;
  logic [CNT_W-1:0]      count_o;
  ifq_state_e            state_dbg;

  modport master (
    input  jumpFlag_i, jumpAddr_i, dataOk_i, inst_fetch_i, ready_i,
    output request_o, instAddr_fetch_o, valid_o, inst_o, instAddr_o, pID_o,
           count_o, state_dbg
  );

  modport slave (
    output jumpFlag_i, jumpAddr_i, dataOk_i, inst_fetch_i, ready_i,
    input  request_o, instAddr_fetch_o, valid_o, inst_o, instAddr_o, pID_o,
           count_o, state_dbg
  );

endinterface

// File: rtl/ifq_fifo.sv
// ifq_fifo
// Synchronous DEPTH-entry FIFO for the fetch queue.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (storage cleared too)
//   flush_i      empties the FIFO (pointers and count to 0); wins over wr/rd
//   wr_en_i      write wr_data_i at the tail
//   rd_en_i      pop the head
//   rd_data_o    head entry (storage at the read pointer)
//   count_o      number of stored entries, 0..DEPTH
//   empty_o      count_o == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// The caller guarantees no write when full unless a read happens the same
// cycle, and no read when empty.
module ifq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_en_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(wr_en_i) - CNT_W'(rd_en_i);
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
// Bnine fetch stage: PC generation, single-outstanding instruction fetch and
// a DEPTH-entry queue of {pID, address, instruction} towards the decoder.
// Ports:
//   clk       clock, rising edge
//   reset_n   asynchronous active-low reset
//   ifq       inst_fetch_queue_if.master: redirect, memory request/response,
//             decoder head port, count_o, state_dbg
// Optional feature: define IFQ_BYPASS_EN to forward a response straight to
// the decoder in its arrival cycle when the queue is empty and ready_i=1.
module inst_fetch_queue
  import bnine_ifq_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter int                    PID_WIDTH  = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input logic                clk,
  input logic                reset_n,
  inst_fetch_queue_if.master ifq
);

  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int ENTRY_W  = entry_width(INST_WIDTH, ADDR_WIDTH, PID_WIDTH);
  localparam int ADDR_LSB = entry_addr_lsb(INST_WIDTH);
  localparam int PID_LSB  = entry_pid_lsb(INST_WIDTH, ADDR_WIDTH);

  ifq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;   // address of the outstanding request
  logic [PID_WIDTH-1:0]  pid_q, pid_d;

  logic                  jump;
  logic                  dok;
  logic                  rsp_accept;
  logic                  bypass;
  logic                  enq;
  logic                  deq;
  logic                  space;
  logic                  issue;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    head_entry;

  assign jump = ifq.jumpFlag_i;
  assign dok  = ifq.dataOk_i;

  // A response is kept only when it answers a live request and no redirect
  // is happening in the same cycle.
  assign rsp_accept = dok && (state_q == ST_WAIT) && !jump;

`ifdef IFQ_BYPASS_EN
  assign bypass = rsp_accept && fifo_empty && ifq.ready_i;
`else
  assign bypass = 1'b0;
`endif

  assign enq = rsp_accept && !bypass;
  // A handshake during a redirect is void; the queue is flushed anyway.
  assign deq = !fifo_empty && ifq.ready_i && !jump;

  assign count_next = count + CNT_W'(enq) - CNT_W'(deq);
  assign space      = (count_next < CNT_W'(DEPTH));

  // reset_n gates the pulse so no request leaves while reset is held.
  assign issue = reset_n && !jump && space &&
                 ((state_q == ST_IDLE) ||
                  (state_q == ST_WAIT && dok) ||
                  (state_q == ST_DROP && dok));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    pid_d      = pid_q;

    if (rsp_accept) begin
      pid_d = pid_q + PID_WIDTH'(1);
    end

    if (jump) begin
      pc_d = ifq.jumpAddr_i;
      // A request still in flight must have its response swallowed.
      state_d = ((state_q != ST_IDLE) && !dok) ? ST_DROP : ST_IDLE;
    end else if (issue) begin
      pc_d       = pc_q + ADDR_WIDTH'(PC_STEP);
      req_addr_d = pc_q;
      state_d    = ST_WAIT;
    end else if (dok && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      pid_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      pid_q      <= pid_d;
    end
  end

  assign wr_entry = {pid_q, req_addr_q, ifq.inst_fetch_i};

  ifq_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .flush_i   (jump),
    .wr_en_i   (enq),
    .wr_data_i (wr_entry),
    .rd_en_i   (deq),
    .rd_data_o (head_entry),
    .count_o   (count),
    .empty_o   (fifo_empty)
  );

  assign ifq.request_o        = issue;
  assign ifq.instAddr_fetch_o = pc_q;
  assign ifq.valid_o          = !jump && (!fifo_empty || bypass);
  assign ifq.inst_o           = bypass ? ifq.inst_fetch_i
                                       : head_entry[ENTRY_INST_LSB +: INST_WIDTH];
  assign ifq.instAddr_o       = bypass ? req_addr_q
                                       : head_entry[ADDR_LSB +: ADDR_WIDTH];
  assign ifq.pID_o            = bypass ? pid_q
                                       : head_entry[PID_LSB +: PID_WIDTH];
  assign ifq.count_o          = count;
  assign ifq.state_dbg        = state_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue
// Directed bench for inst_fetch_queue (ADDR/INST 32, DEPTH 4, PID 2).
// Inputs change on the falling edge; outputs are sampled 1 ns later, i.e.
// within the same cycle and away from the rising edge.
module tb_inst_fetch_queue;
  import bnine_ifq_pkg::*;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];

  inst_fetch_queue_if #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .DEPTH      (4),
    .PID_WIDTH  (2)
  ) ifq ();

  inst_fetch_queue #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .DEPTH      (4),
    .PID_WIDTH  (2),
    .RESET_PC   (32'h0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ifq     (ifq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Instruction word the memory returns for a given address.
  function automatic logic [31:0] iw(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic jf, input logic [31:0] ja, input logic dok,
                       input logic [31:0] inst, input logic rdy);
    @(negedge clk);
    ifq.jumpFlag_i   = jf;
    ifq.jumpAddr_i   = ja;
    ifq.dataOk_i     = dok;
    ifq.inst_fetch_i = inst;
    ifq.ready_i      = rdy;
    #1;
  endtask

  // Holds reset for two edges, releases it on a falling edge and leaves the
  // bench inside the first cycle out of reset with the given inputs.
  task automatic do_reset(input logic rdy, input logic dok, input logic [31:0] inst);
    reset_n          = 1'b0;
    ifq.jumpFlag_i   = 1'b0;
    ifq.jumpAddr_i   = '0;
    ifq.dataOk_i     = 1'b0;
    ifq.inst_fetch_i = '0;
    ifq.ready_i      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n          = 1'b1;
    ifq.dataOk_i     = dok;
    ifq.inst_fetch_i = inst;
    ifq.ready_i      = rdy;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_n          = 1'b0;
    ifq.jumpFlag_i   = 1'b0;
    ifq.jumpAddr_i   = '0;
    ifq.dataOk_i     = 1'b0;
    ifq.inst_fetch_i = '0;
    ifq.ready_i      = 1'b1;
    #3;
    checks++;
    if (ifq.request_o !== 1'b0) begin
      errors++; $display("FAIL rst_request: got %b expected 0", ifq.request_o);
    end
    checks++;
    if ({ifq.valid_o, ifq.count_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o} !== 70'h0) begin
      errors++; $display("FAIL rst_head: got %h expected 0",
                         {ifq.valid_o, ifq.count_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o});
    end
    checks++;
    if (ifq.instAddr_fetch_o !== 32'h0) begin
      errors++; $display("FAIL rst_fetch_addr: got %h expected 0", ifq.instAddr_fetch_o);
    end
    checks++;
    if (ifq.state_dbg !== ST_IDLE) begin
      errors++; $display("FAIL rst_state: got %0d expected %0d", ifq.state_dbg, ST_IDLE);
    end
  endtask

  task automatic test_zero_latency;
    do_reset(1'b1, 1'b0, 32'h0);
    checks++;
    if ({ifq.request_o, ifq.instAddr_fetch_o} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL zl_req0: got %h expected 100000000", {ifq.request_o, ifq.instAddr_fetch_o});
    end
    drive(1'b0, 32'h0, 1'b1, iw(32'h0), 1'b1);
    checks++;
    if ({ifq.request_o, ifq.instAddr_fetch_o, ifq.valid_o} !== {1'b1, 32'h4, 1'b0}) begin
      errors++; $display("FAIL zl_req4: got %h expected %h",
                         {ifq.request_o, ifq.instAddr_fetch_o, ifq.valid_o}, {1'b1, 32'h4, 1'b0});
    end
    drive(1'b0, 32'h0, 1'b1, iw(32'h4), 1'b1);
    checks++;
    if ({ifq.request_o, ifq.instAddr_fetch_o} !== {1'b1, 32'h8}) begin
      errors++; $display("FAIL zl_req8: got %h expected 100000008", {ifq.request_o, ifq.instAddr_fetch_o});
    end
    checks++;
    if ({ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o} !== {1'b1, iw(32'h0), 32'h0, 2'd0}) begin
      errors++; $display("FAIL zl_head0: got %h expected %h",
                         {ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o}, {1'b1, iw(32'h0), 32'h0, 2'd0});
    end
    drive(1'b0, 32'h0, 1'b1, iw(32'h8), 1'b1);
    checks++;
    if ({ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o} !== {1'b1, iw(32'h4), 32'h4, 2'd1}) begin
      errors++; $display("FAIL zl_head1: got %h expected %h",
                         {ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o}, {1'b1, iw(32'h4), 32'h4, 2'd1});
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o} !== {1'b1, iw(32'h8), 32'h8, 2'd2}) begin
      errors++; $display("FAIL zl_head2: got %h expected %h",
                         {ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o}, {1'b1, iw(32'h8), 32'h8, 2'd2});
    end
    checks++;
    if ({ifq.request_o, ifq.count_o} !== {1'b0, 3'd1}) begin
      errors++; $display("FAIL zl_wait: got %h expected 1", {ifq.request_o, ifq.count_o});
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({ifq.valid_o, ifq.count_o} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL zl_drained: got %h expected 0", {ifq.valid_o, ifq.count_o});
    end
  endtask

  task automatic test_full;
    do_reset(1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, iw(32'h0), 1'b0);
    drive(1'b0, 32'h0, 1'b1, iw(32'h4), 1'b0);
    drive(1'b0, 32'h0, 1'b1, iw(32'h8), 1'b0);
    checks++;
    if ({ifq.request_o, ifq.instAddr_fetch_o, ifq.count_o} !== {1'b1, 32'hC, 3'd2}) begin
      errors++; $display("FAIL full_req_c: got %h expected %h",
                         {ifq.request_o, ifq.instAddr_fetch_o, ifq.count_o}, {1'b1, 32'hC, 3'd2});
    end
    drive(1'b0, 32'h0, 1'b1, iw(32'hC), 1'b0);
    checks++;
    if ({ifq.request_o, ifq.count_o} !== {1'b0, 3'd3}) begin
      errors++; $display("FAIL full_last_enq: got %h expected 3", {ifq.request_o, ifq.count_o});
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checks++;
    if ({ifq.request_o, ifq.count_o} !== {1'b0, 3'd4}) begin
      errors++; $display("FAIL full_count4: got %h expected 4", {ifq.request_o, ifq.count_o});
    end
    checks++;
    if ({ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o} !== {1'b1, iw(32'h0), 32'h0, 2'd0}) begin
      errors++; $display("FAIL full_head0: got %h expected %h",
                         {ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o}, {1'b1, iw(32'h0), 32'h0, 2'd0});
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (ifq.request_o !== 1'b0) begin
      errors++; $display("FAIL full_hold: got %b expected 0", ifq.request_o);
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({ifq.request_o, ifq.instAddr_fetch_o} !== {1'b1, 32'h10}) begin
      errors++; $display("FAIL full_pulse_req: got %h expected 100000010", {ifq.request_o, ifq.instAddr_fetch_o});
    end
    drive(1'b0, 32'h0, 1'b1, iw(32'h10), 1'b0);
    checks++;
    if ({ifq.request_o, ifq.count_o, ifq.instAddr_o, ifq.pID_o} !== {1'b0, 3'd3, 32'h4, 2'd1}) begin
      errors++; $display("FAIL full_refill: got %h expected %h",
                         {ifq.request_o, ifq.count_o, ifq.instAddr_o, ifq.pID_o}, {1'b0, 3'd3, 32'h4, 2'd1});
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({ifq.request_o, ifq.instAddr_fetch_o, ifq.count_o} !== {1'b1, 32'h14, 3'd4}) begin
      errors++; $display("FAIL full_req14: got %h expected %h",
                         {ifq.request_o, ifq.instAddr_fetch_o, ifq.count_o}, {1'b1, 32'h14, 3'd4});
    end
    drive(1'b0, 32'h0, 1'b1, iw(32'h14), 1'b1);
    checks++;
    if ({ifq.request_o, ifq.instAddr_fetch_o, ifq.count_o, ifq.inst_o, ifq.pID_o} !==
        {1'b1, 32'h18, 3'd3, iw(32'h8), 2'd2}) begin
      errors++; $display("FAIL full_enq_deq: got %h expected %h",
                         {ifq.request_o, ifq.instAddr_fetch_o, ifq.count_o, ifq.inst_o, ifq.pID_o},
                         {1'b1, 32'h18, 3'd3, iw(32'h8), 2'd2});
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checks++;
    if ({ifq.count_o, ifq.instAddr_o, ifq.pID_o} !== {3'd3, 32'hC, 2'd3}) begin
      errors++; $display("FAIL full_count_kept: got %h expected %h",
                         {ifq.count_o, ifq.instAddr_o, ifq.pID_o}, {3'd3, 32'hC, 2'd3});
    end
  endtask

  task automatic test_jump_drop;
    do_reset(1'b1, 1'b0, 32'h0);
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({ifq.request_o, ifq.valid_o} !== 2'b00) begin
      errors++; $display("FAIL jd_jump_cycle: got %b expected 00", {ifq.request_o, ifq.valid_o});
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({ifq.request_o, ifq.state_dbg} !== {1'b0, ST_DROP}) begin
      errors++; $display("FAIL jd_drop_state: got %h expected %h", {ifq.request_o, ifq.state_dbg}, {1'b0, ST_DROP});
    end
    drive(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    checks++;
    if ({ifq.request_o, ifq.instAddr_fetch_o} !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL jd_req100: got %h expected 100000100", {ifq.request_o, ifq.instAddr_fetch_o});
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({ifq.request_o, ifq.valid_o, ifq.count_o} !== {1'b0, 1'b0, 3'd0}) begin
      errors++; $display("FAIL jd_stale_dropped: got %h expected 0", {ifq.request_o, ifq.valid_o, ifq.count_o});
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b1, iw(32'h100), 1'b1);
    checks++;
    if ({ifq.request_o, ifq.instAddr_fetch_o} !== {1'b1, 32'h104}) begin
      errors++; $display("FAIL jd_req104: got %h expected 100000104", {ifq.request_o, ifq.instAddr_fetch_o});
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o} !== {1'b1, iw(32'h100), 32'h100, 2'd0}) begin
      errors++; $display("FAIL jd_head: got %h expected %h",
                         {ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o}, {1'b1, iw(32'h100), 32'h100, 2'd0});
    end
  endtask

  task automatic test_jump_with_data;
    do_reset(1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, iw(32'h0), 1'b0);
    drive(1'b0, 32'h0, 1'b1, iw(32'h4), 1'b0);
    drive(1'b1, 32'h200, 1'b1, iw(32'h8), 1'b1);
    checks++;
    if ({ifq.valid_o, ifq.request_o} !== 2'b00) begin
      errors++; $display("FAIL jw_jump_cycle: got %b expected 00", {ifq.valid_o, ifq.request_o});
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({ifq.request_o, ifq.instAddr_fetch_o, ifq.count_o, ifq.valid_o} !== {1'b1, 32'h200, 3'd0, 1'b0}) begin
      errors++; $display("FAIL jw_req200: got %h expected %h",
                         {ifq.request_o, ifq.instAddr_fetch_o, ifq.count_o, ifq.valid_o}, {1'b1, 32'h200, 3'd0, 1'b0});
    end
    drive(1'b0, 32'h0, 1'b1, iw(32'h200), 1'b1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o} !== {1'b1, iw(32'h200), 32'h200, 2'd2}) begin
      errors++; $display("FAIL jw_head: got %h expected %h",
                         {ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o}, {1'b1, iw(32'h200), 32'h200, 2'd2});
    end
  endtask

  task automatic test_pid_wrap;
    logic [1:0] exp_pid [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] a;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    do_reset(1'b1, 1'b0, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 32'h0, (k <= 5), iw(32'(4 * (k - 1))), 1'b1);
      if (k >= 2) begin
        a = exp_q.pop_front();
        checks++;
        if ({ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o} !== {1'b1, iw(a), a, exp_pid[k-2]}) begin
          errors++; $display("FAIL pid_seq[%0d]: got %h expected %h", k - 2,
                             {ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o}, {1'b1, iw(a), a, exp_pid[k-2]});
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pid_leftover: got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_request;
    do_reset(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ifq.request_o, ifq.state_dbg, ifq.instAddr_fetch_o} !== {1'b0, ST_IDLE, 32'h0}) begin
      errors++; $display("FAIL mid_reset_clear: got %h expected %h",
                         {ifq.request_o, ifq.state_dbg, ifq.instAddr_fetch_o}, {1'b0, ST_IDLE, 32'h0});
    end
    do_reset(1'b1, 1'b1, 32'hBAD0_0000);
    checks++;
    if ({ifq.request_o, ifq.instAddr_fetch_o} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL mid_req0: got %h expected 100000000", {ifq.request_o, ifq.instAddr_fetch_o});
    end
    drive(1'b0, 32'h0, 1'b1, iw(32'h0), 1'b1);
    checks++;
    if ({ifq.valid_o, ifq.count_o} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL mid_late_ignored: got %h expected 0", {ifq.valid_o, ifq.count_o});
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o} !== {1'b1, iw(32'h0), 32'h0, 2'd0}) begin
      errors++; $display("FAIL mid_head: got %h expected %h",
                         {ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o}, {1'b1, iw(32'h0), 32'h0, 2'd0});
    end
  endtask

  task automatic test_bypass;
    do_reset(1'b1, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, iw(32'h0), 1'b1);
`ifdef IFQ_BYPASS_EN
    checks++;
    if ({ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o, ifq.count_o} !==
        {1'b1, iw(32'h0), 32'h0, 2'd0, 3'd0}) begin
      errors++; $display("FAIL byp_same_cycle: got %h expected %h",
                         {ifq.valid_o, ifq.inst_o, ifq.instAddr_o, ifq.pID_o, ifq.count_o},
                         {1'b1, iw(32'h0), 32'h0, 2'd0, 3'd0});
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({ifq.valid_o, ifq.count_o} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL byp_not_queued: got %h expected 0", {ifq.valid_o, ifq.count_o});
    end
`else
    checks++;
    if (ifq.valid_o !== 1'b0) begin
      errors++; $display("FAIL nobyp_same_cycle: got %b expected 0", ifq.valid_o);
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({ifq.valid_o, ifq.count_o, ifq.inst_o} !== {1'b1, 3'd1, iw(32'h0)}) begin
      errors++; $display("FAIL nobyp_next_cycle: got %h expected %h",
                         {ifq.valid_o, ifq.count_o, ifq.inst_o}, {1'b1, 3'd1, iw(32'h0)});
    end
`endif
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset;
    test_zero_latency;
    test_full;
    test_jump_drop;
    test_jump_with_data;
    test_pid_wrap;
    test_reset_mid_request;
    test_bypass;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised next-generation instruction fetch stage for the Bnine core. Merges PC generation and instruction fetch into one block, issues single-beat requests to instruction memory, and buffers returned instructions in a DEPTH-entry queue. Each queued instruction is tagged with its address and a wrapping pipeline ID. Sits between instruction memory and the decoder of a way. Supports jump flush with discard of an in-flight response.

## Interface
Parameters:
- ADDR_WIDTH, 32, instruction address width
- INST_WIDTH, 32, instruction word width
- DEPTH, 4, queue entries; power of two, ≥2
- PID_WIDTH, 2, pipeline ID width
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- jumpFlag_i  in  1  redirect PC and flush
- jumpAddr_i  in  ADDR_WIDTH  redirect target
- request_o  out  1  one-cycle fetch request pulse
- instAddr_fetch_o  out  ADDR_WIDTH  fetch address; valid while request_o=1
- dataOk_i  in  1  one-cycle response strobe; exactly one per accepted request
- inst_fetch_i  in  INST_WIDTH  response data; valid with dataOk_i
- valid_o  out  1  queue head valid to decoder
- ready_i  in  1  decoder accepts head
- inst_o  out  INST_WIDTH  head instruction
- instAddr_o  out  ADDR_WIDTH  head address
- pID_o  out  PID_WIDTH  head pipeline ID
- count_o  out  $clog2(DEPTH)+1  queued entries

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding.
  - DROP: one request outstanding; its response is discarded.
- Maximum outstanding requests: 1.
- Space condition: `count_next < DEPTH`, where count_next includes this cycle's enqueue and dequeue.
- request_o is combinational:
  - Asserted when jumpFlag_i=0, the space condition holds, and any one of the following is true:
    - state=IDLE
    - state=WAIT and dataOk_i=1
    - state=DROP and dataOk_i=1
  - On issue: PC += 4; state → WAIT.
- Response handling:
  - dataOk_i in WAIT with jumpFlag_i=0: enqueue {pID_ctr, fetch address of that request, inst_fetch_i}; pID_ctr increments mod 2^PID_WIDTH.
  - dataOk_i in DROP: no enqueue.
  - dataOk_i in IDLE: protocol error, ignored.
- Next state after a response with no re-issue: IDLE.
- Dequeue occurs when valid_o && ready_i.
- jumpFlag_i (highest priority):
  - PC ← jumpAddr_i.
  - Queue cleared (count=0).
  - No issue in the jump cycle.
  - State → DROP if a request is outstanding and dataOk_i=0; otherwise IDLE.
  - pID_ctr is not reset.
- Reset values:
  - PC=RESET_PC; state=IDLE; pID_ctr=0; queue storage and pointers 0.
  - request_o=0, valid_o=0, count_o=0, inst_o=0, instAddr_o=0, pID_o=0, instAddr_fetch_o=RESET_PC.

## Timing
- Fetch-to-queue: response registered into the queue on the dataOk_i edge. valid_o rises the following cycle when the queue was empty.
- Throughput: one request per cycle when memory answers in the same cycle as request_o and space holds. With N-cycle memory latency, one instruction per N cycles.
- valid_o is forced to 0 in any cycle with jumpFlag_i=1. A handshake in that cycle has no effect.
- Full queue: no request issued. Issue resumes in the cycle a dequeue makes count_next < DEPTH.
- Simultaneous enqueue and dequeue on a full queue: count unchanged. Issue is allowed that cycle if count_next < DEPTH.
- Pointer wrap at DEPTH is modular. Count saturates by construction and never exceeds DEPTH.
- Reset mid-request: all state clears immediately. A late dataOk_i after reset arrives in IDLE and is ignored.

## Configuration
- IFQ_BYPASS_EN defined:
  - When the queue is empty, dataOk_i is accepted in WAIT, and ready_i=1, the response is presented combinationally on inst_o/instAddr_o/pID_o with valid_o=1 in the same cycle.
  - The response is not written to the queue; pID_ctr still increments.
- IFQ_BYPASS_EN undefined: minimum fetch-to-decoder latency is 1 cycle, always through the queue.

## Structure
- Shared package bnine_ifq_pkg holds:
  - FSM state encoding (IDLE/WAIT/DROP)
  - Entry field offsets/width
  - Default RESET_PC
- Sub-module ifq_fifo: synchronous DEPTH-entry FIFO with flush, enqueue, dequeue, count.
- PC, FSM and pID counter live in inst_fetch_queue.

## Test plan
- Reset, zero-latency memory, ready_i=1 → requests at 0x0, 0x4, 0x8 on consecutive cycles; outputs pID 0,1,2 with matching addresses.
- ready_i=0, DEPTH=4 → exactly 4 entries queued, count_o=4, request_o stays 0. One ready_i pulse → one new request within the same cycle.
- 3-cycle memory latency, jumpFlag_i with jumpAddr_i=0x100 one cycle after the request → stale response discarded, next request at 0x100, queue empty after the jump.
- jumpFlag_i coincident with dataOk_i → no enqueue, valid_o=0 that cycle, next-cycle request at the jump address.
- 5 sequential instructions with PID_WIDTH=2 → pID_o sequence 0,1,2,3,0.
- IFQ_BYPASS_EN, empty queue, ready_i=1 → valid_o and inst_o match inst_fetch_i in the dataOk_i cycle, count_o stays 0.
